// File: rtl/muldiv_issue_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_issue_ctrl_pkg
// Shared definitions for the execute-stage divide initiator:
//   - M-extension divide/remainder opcode constants (INST_*) and ZEROWORD
//   - FSM state encoding (IDLE / ISSUE / DONE)
//   - opcode class predicates: is_legal, is_signed, is_word, is_rem
//   - default issue timeout
// -----------------------------------------------------------------------------
package muldiv_issue_ctrl_pkg;

  localparam logic [7:0] INST_DIV   = 8'h30;
  localparam logic [7:0] INST_DIVU  = 8'h31;
  localparam logic [7:0] INST_REM   = 8'h32;
  localparam logic [7:0] INST_REMU  = 8'h33;
  localparam logic [7:0] INST_DIVW  = 8'h34;
  localparam logic [7:0] INST_DIVUW = 8'h35;
  localparam logic [7:0] INST_REMW  = 8'h36;
  localparam logic [7:0] INST_REMUW = 8'h37;

  localparam logic [31:0] ZEROWORD = 32'h0;

  localparam int DEF_TIMEOUT_CYC = 160;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_legal(input logic [7:0] op);
    case (op)
      INST_DIV, INST_DIVU, INST_REM, INST_REMU,
      INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW: is_legal = 1'b1;
      default:                                      is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed(input logic [7:0] op);
    is_signed = (op == INST_DIV) || (op == INST_REM) ||
                (op == INST_DIVW) || (op == INST_REMW);
  endfunction

  function automatic logic is_word(input logic [7:0] op);
    is_word = (op == INST_DIVW) || (op == INST_DIVUW) ||
              (op == INST_REMW) || (op == INST_REMUW);
  endfunction

  function automatic logic is_rem(input logic [7:0] op);
    is_rem = (op == INST_REM) || (op == INST_REMU) ||
             (op == INST_REMW) || (op == INST_REMUW);
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// -----------------------------------------------------------------------------
// muldiv_fixup
// Purely combinational RISC-V result correction for the divider.
// Ports:
//   raw        unsigned quotient/remainder magnitude from the divider
//   op1        numerator after W narrowing (returned on divide-by-zero REM,
//              and as the quotient on signed overflow)
//   neg1/neg2  operand sign flags (zero for unsigned ops)
//   rem_sign   remainder takes the sign of the numerator
//   rem_op     op is a remainder, else a quotient
//   word_op    W variant: final value sign-extended from bit 31
//   div_zero   denominator is zero
//   sgn_ovf    most-negative / -1 signed overflow
//   result     final rd value
// -----------------------------------------------------------------------------
module muldiv_fixup #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] raw,
  input  logic [XLEN-1:0] op1,
  input  logic            neg1,
  input  logic            neg2,
  input  logic            rem_sign,
  input  logic            rem_op,
  input  logic            word_op,
  input  logic            div_zero,
  input  logic            sgn_ovf,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] pre;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pre = raw;
    if (div_zero) begin
      pre = rem_op ? op1 : '1;
    end else if (sgn_ovf) begin
      pre = rem_op ? '0 : op1;
    end else if (rem_op) begin
      pre = rem_sign ? -raw : raw;
    end else begin
      pre = (neg1 ^ neg2) ? -raw : raw;
    end

    result = pre;
    if (word_op) begin
      result = {{(XLEN-32){pre[31]}}, pre[31:0]};
    end
  end

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_issue_ctrl
// Execute-stage initiator for the iterative divider. Accepts one divide /
// remainder op from EX, narrows W operands, hands magnitudes to the divider,
// runs the ready/finish handshake with a timeout, and applies the RISC-V sign
// and corner-case fixups before a one-cycle write-back pulse.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   ex_valid/ex_opcode/ex_op1/ex_op2   op from EX
//   flush                       abort any op in flight
//   ex_stall                    hold EX while the op is being accepted/issued
//   wb_valid/wb_data/wb_err     one-cycle result (wb_err = timeout abort)
//   div_divisor/div_dividend    |op1| / |op2| to the divider (port names are
//                               historical: div_divisor carries the numerator)
//   div_opcode/div_ready        opcode and request to the divider
//   div_rem_data/div_finish     divider result and completion pulse
// Build option: MULDIV_FASTPATH_EN resolves divide-by-zero, signed overflow
// and op2==1 in IDLE without ever raising div_ready.
// -----------------------------------------------------------------------------
module muldiv_issue_ctrl
  import muldiv_issue_ctrl_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [7:0]      ex_opcode,
  input  logic [XLEN-1:0] ex_op1,
  input  logic [XLEN-1:0] ex_op2,
  input  logic            flush,
  output logic            ex_stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err,
  output logic [XLEN-1:0] div_divisor,
  output logic [XLEN-1:0] div_dividend,
  output logic [7:0]      div_opcode,
  output logic            div_ready,
  input  logic [XLEN-1:0] div_rem_data,
  input  logic            div_finish
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  op1_q;
  logic             neg1_q, neg2_q, div0_q, ovf_q;
  logic             wb_err_q;

  // ---- decode of the incoming op ----
  logic            legal, sgn_d, word_d;
  logic [XLEN-1:0] op1_d, op2_d, abs1_d, abs2_d, min_d;
  logic            neg1_d, neg2_d, div0_d, ovf_d, fast_d, accept;

  assign legal  = is_legal(ex_opcode);
  assign sgn_d  = is_signed(ex_opcode);
  assign word_d = is_word(ex_opcode);

  always_comb begin
    op1_d = ex_op1;
    op2_d = ex_op2;
    if (word_d) begin
      op1_d = sgn_d ? {{(XLEN-32){ex_op1[31]}}, ex_op1[31:0]} : XLEN'(ex_op1[31:0]);
      op2_d = sgn_d ? {{(XLEN-32){ex_op2[31]}}, ex_op2[31:0]} : XLEN'(ex_op2[31:0]);
    end
  end

  // Most negative value at the op's width, already sign-extended for W ops.
  assign min_d  = word_d ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};

  assign neg1_d = sgn_d & op1_d[XLEN-1];
  assign neg2_d = sgn_d & op2_d[XLEN-1];
  assign abs1_d = neg1_d ? -op1_d : op1_d;
  assign abs2_d = neg2_d ? -op2_d : op2_d;
  assign div0_d = (op2_d == '0);
  assign ovf_d  = sgn_d & (op1_d == min_d) & (op2_d == '1);

`ifdef MULDIV_FASTPATH_EN
  assign fast_d = div0_d | ovf_d | (op2_d == XLEN'(1));
`else
  assign fast_d = 1'b0;
`endif

  assign accept = (state == ST_IDLE) & ex_valid & legal & ~flush;

  // ---- fixup: decoded inputs in IDLE (fast path), latched inputs otherwise ----
  logic            idle;
  logic [XLEN-1:0] fx_raw, fx_op1, fx_res;
  logic            fx_neg1, fx_neg2, fx_rem, fx_word, fx_div0, fx_ovf;

  assign idle    = (state == ST_IDLE);
  // For op2==1 the quotient magnitude is |op1| and the remainder is zero.
  assign fx_raw  = idle ? (is_rem(ex_opcode) ? '0 : abs1_d) : div_rem_data;
  assign fx_op1  = idle ? op1_d  : op1_q;
  assign fx_neg1 = idle ? neg1_d : neg1_q;
  assign fx_neg2 = idle ? neg2_d : neg2_q;
  assign fx_rem  = idle ? is_rem(ex_opcode)  : is_rem(div_opcode);
  assign fx_word = idle ? word_d             : is_word(div_opcode);
  assign fx_div0 = idle ? div0_d : div0_q;
  assign fx_ovf  = idle ? ovf_d  : ovf_q;

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .raw      (fx_raw),
    .op1      (fx_op1),
    .neg1     (fx_neg1),
    .neg2     (fx_neg2),
    .rem_sign (fx_neg1),
    .rem_op   (fx_rem),
    .word_op  (fx_word),
    .div_zero (fx_div0),
    .sgn_ovf  (fx_ovf),
    .result   (fx_res)
  );

  // The first ISSUE cycle (cnt==0) ignores div_finish to reject a stale pulse.
  logic fin_ok, timed_out;
  assign fin_ok    = div_finish & (cnt != '0);
  assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      op1_q        <= '0;
      neg1_q       <= 1'b0;
      neg2_q       <= 1'b0;
      div0_q       <= 1'b0;
      ovf_q        <= 1'b0;
      wb_err_q     <= 1'b0;
      wb_data      <= '0;
      div_divisor  <= '0;
      div_dividend <= '0;
      div_opcode   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op1_q        <= op1_d;
            neg1_q       <= neg1_d;
            neg2_q       <= neg2_d;
            div0_q       <= div0_d;
            ovf_q        <= ovf_d;
            div_divisor  <= abs1_d;
            div_dividend <= abs2_d;
            div_opcode   <= ex_opcode;
            cnt          <= '0;
            wb_err_q     <= 1'b0;
            if (fast_d) begin
              wb_data <= fx_res;
              state   <= ST_DONE;
            end else begin
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          cnt <= cnt + 1'b1;
          if (flush) begin
            state <= ST_IDLE;
          end else if (fin_ok) begin
            wb_data  <= fx_res;
            wb_err_q <= 1'b0;
            state    <= ST_DONE;
          end else if (timed_out) begin
            wb_data  <= XLEN'(ZEROWORD);
            wb_err_q <= 1'b1;
            state    <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign div_ready = (state == ST_ISSUE);
  assign ex_stall  = (state == ST_ISSUE) | ((state == ST_IDLE) & ex_valid & legal);
  // A flush in DONE discards the result instead of writing it back.
  assign wb_valid  = (state == ST_DONE) & ~flush;
  assign wb_err    = wb_err_q & wb_valid;

endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_issue_ctrl
// Directed self-checking bench for muldiv_issue_ctrl with hand-computed
// expected values. Works for both the default and MULDIV_FASTPATH_EN builds.
// -----------------------------------------------------------------------------
module tb_muldiv_issue_ctrl;
  import muldiv_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [7:0]  ex_opcode;
  logic [63:0] ex_op1, ex_op2;
  logic        flush;
  logic        ex_stall, wb_valid, wb_err, div_ready;
  logic [63:0] wb_data, div_divisor, div_dividend, div_rem_data;
  logic [7:0]  div_opcode;
  logic        div_finish;

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FASTPATH_EN
  localparam bit FAST_BUILD = 1'b1;
`else
  localparam bit FAST_BUILD = 1'b0;
`endif

  muldiv_issue_ctrl #(.XLEN(64), .TIMEOUT_CYC(160), .CNT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_opcode    (ex_opcode),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .flush        (flush),
    .ex_stall     (ex_stall),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .wb_err       (wb_err),
    .div_divisor  (div_divisor),
    .div_dividend (div_dividend),
    .div_opcode   (div_opcode),
    .div_ready    (div_ready),
    .div_rem_data (div_rem_data),
    .div_finish   (div_finish)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and drive the divider. A stale finish with garbage data is
  // driven in the first ISSUE cycle; the real finish follows one cycle later.
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] raw, input logic [63:0] exp,
                        input logic [63:0] m1, input logic [63:0] m2,
                        input bit corner);
    ex_valid = 1'b1; ex_opcode = op; ex_op1 = a; ex_op2 = b;
    #1 check({tag, "_stall_acc"}, 64'(ex_stall), 64'd1);
    tick();
    ex_valid = 1'b0;
    if (FAST_BUILD && corner) begin
      check({tag, "_fast_ready"}, 64'(div_ready), 64'd0);
      check({tag, "_fast_valid"}, 64'(wb_valid), 64'd1);
      check({tag, "_fast_data"}, wb_data, exp);
    end else begin
      check({tag, "_ready"}, 64'(div_ready), 64'd1);
      check({tag, "_mag1"}, div_divisor, m1);
      check({tag, "_mag2"}, div_dividend, m2);
      check({tag, "_opc"}, 64'(div_opcode), 64'(op));
      div_finish = 1'b1; div_rem_data = 64'hDEAD_BEEF_0BAD_F00D;
      tick();
      div_finish = 1'b0;
      check({tag, "_stale"}, 64'(wb_valid), 64'd0);
      div_finish = 1'b1; div_rem_data = raw;
      tick();
      div_finish = 1'b0;
      check({tag, "_valid"}, 64'(wb_valid), 64'd1);
      check({tag, "_data"}, wb_data, exp);
      check({tag, "_err"}, 64'(wb_err), 64'd0);
      check({tag, "_stall_done"}, 64'(ex_stall), 64'd0);
      check({tag, "_ready_done"}, 64'(div_ready), 64'd0);
    end
    tick();
    check({tag, "_pulse_end"}, 64'(wb_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; ex_valid = 1'b0; ex_opcode = '0; ex_op1 = '0; ex_op2 = '0;
    flush = 1'b0; div_finish = 1'b0; div_rem_data = '0;
    tick(); tick();
    check("rst_stall", 64'(ex_stall), 64'd0);
    check("rst_valid", 64'(wb_valid), 64'd0);
    check("rst_ready", 64'(div_ready), 64'd0);
    check("rst_data", wb_data, 64'd0);
    check("rst_divisor", div_divisor, 64'd0);
    check("rst_opcode", 64'(div_opcode), 64'd0);
    rst = 1'b0;
    tick();

    // DIV -20/3 -> -6 ; REM -20/3 -> -2 ; REM 20/-3 -> 2
    run_op("div_neg", INST_DIV, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd6,
           64'hFFFF_FFFF_FFFF_FFFA, 64'd20, 64'd3, 1'b0);
    run_op("rem_neg", INST_REM, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFE, 64'd20, 64'd3, 1'b0);
    run_op("rem_negd", INST_REM, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2,
           64'd2, 64'd20, 64'd3, 1'b0);
    // Divide by zero
    run_op("divu_z", INST_DIVU, 64'd7, 64'd0, 64'h1234,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd0, 1'b1);
    run_op("remu_z", INST_REMU, 64'd7, 64'd0, 64'h1234,
           64'd7, 64'd7, 64'd0, 1'b1);
    // W signed overflow
    run_op("divw_ovf", INST_DIVW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 64'd1, 1'b1);
    run_op("remw_ovf", INST_REMW, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 64'd0, 64'h8000_0000, 64'd1, 1'b1);
    // W narrowing ignores upper bits: 100 / -10 -> -10 ; DIVUW 0x10/5 -> 3
    run_op("divw_nar", INST_DIVW, 64'h1234_5678_0000_0064, 64'h0000_0000_FFFF_FFF6,
           64'd10, 64'hFFFF_FFFF_FFFF_FFF6, 64'd100, 64'd10, 1'b0);
    run_op("divuw_nar", INST_DIVUW, 64'h0000_0001_0000_0010, 64'hABCD_0000_0000_0005,
           64'd3, 64'd3, 64'd16, 64'd5, 1'b0);
    // op2 == 1 (fast-path eligible): -9 / 1 -> -9
    run_op("div_one", INST_DIV, 64'hFFFF_FFFF_FFFF_FFF7, 64'd1, 64'd9,
           64'hFFFF_FFFF_FFFF_FFF7, 64'd9, 64'd1, 1'b1);

    // Illegal opcode: ignored, no stall
    ex_valid = 1'b1; ex_opcode = 8'hFF; ex_op1 = 64'd5; ex_op2 = 64'd2;
    #1 check("illegal_stall", 64'(ex_stall), 64'd0);
    tick();
    ex_valid = 1'b0;
    check("illegal_ready", 64'(div_ready), 64'd0);

    // Flush with ex_valid in IDLE: op not accepted
    ex_valid = 1'b1; ex_opcode = INST_DIV; ex_op1 = 64'd50; ex_op2 = 64'd7; flush = 1'b1;
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    check("idle_flush_ready", 64'(div_ready), 64'd0);
    check("idle_flush_valid", 64'(wb_valid), 64'd0);

    // Flush two cycles into ISSUE, then a late finish: no write-back
    ex_valid = 1'b1; ex_opcode = INST_DIV; ex_op1 = 64'd50; ex_op2 = 64'd7;
    tick();
    ex_valid = 1'b0;
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_ready", 64'(div_ready), 64'd0);
    check("flush_valid", 64'(wb_valid), 64'd0);
    div_finish = 1'b1; div_rem_data = 64'd7;
    tick();
    div_finish = 1'b0;
    check("flush_late_valid", 64'(wb_valid), 64'd0);
    check("flush_late_stall", 64'(ex_stall), 64'd0);
    run_op("div_after_flush", INST_DIV, 64'd50, 64'd7, 64'd7,
           64'd7, 64'd50, 64'd7, 1'b0);

    // Timeout: divider never finishes
    ex_valid = 1'b1; ex_opcode = INST_DIVU; ex_op1 = 64'd99; ex_op2 = 64'd5;
    tick();
    ex_valid = 1'b0;
    n = 0;
    while (div_ready && n < 300) begin
      n++;
      tick();
    end
    check("to_cycles", 64'(n), 64'd160);
    check("to_valid", 64'(wb_valid), 64'd1);
    check("to_err", 64'(wb_err), 64'd1);
    check("to_data", wb_data, 64'd0);
    check("to_stall", 64'(ex_stall), 64'd0);
    tick();
    check("to_pulse_end", 64'(wb_valid), 64'd0);

    // Reset mid-operation
    ex_valid = 1'b1; ex_opcode = INST_DIV; ex_op1 = 64'd40; ex_op2 = 64'd5;
    tick();
    ex_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_ready", 64'(div_ready), 64'd0);
    check("midrst_divisor", div_divisor, 64'd0);
    check("midrst_stall", 64'(ex_stall), 64'd0);
    check("midrst_valid", 64'(wb_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
